// File: rtl/rdru.sv
// rtl/rdru.sv - read-data return unit: routes memory read data back to the i, d and c requesters
// A tag pipeline tracks reads in flight. i returns are one-cycle pulses; d and c returns wait in valid/ready holding registers.
module rdru #(
  parameter int DATABITS = 64,
  parameter int LATENCY  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rq_en,
  input  logic [1:0]          rq_muxcode,
  input  logic [DATABITS-1:0] mem_data,
  output logic                i_vld,
  output logic [DATABITS-1:0] i_data,
  output logic                d_vld,
  output logic [DATABITS-1:0] d_data,
  input  logic                d_rdy,
  output logic                c_vld,
  output logic [DATABITS-1:0] c_data,
  input  logic                c_rdy,
  output logic                ovf,
  output logic                err,
  output logic [3:0]          outstanding
);

  typedef enum logic {HOLD_EMPTY = 1'b0, HOLD_FULL = 1'b1} hold_state_e;

  logic [LATENCY-1:0]      tag_en_q, tag_en_d;
  logic [LATENCY-1:0][1:0] tag_mux_q, tag_mux_d;

  logic                ret_en;
  logic [1:0]          ret_mux;
  logic                ret_i;
  logic [1:0]          hold_ret;
  logic [1:0]          hold_rdy;

  logic                i_vld_q, i_vld_d;
  logic [DATABITS-1:0] i_data_q, i_data_d;

  hold_state_e               hold_q [2];
  hold_state_e               hold_d [2];
  logic [1:0]                hold_vld;
  logic [1:0]                hold_load;
  logic [1:0]                hold_drop;
  logic [1:0][DATABITS-1:0]  hold_data_q, hold_data_d;

  logic       ovf_q, ovf_d;
  logic       err_q, err_d;
  logic [3:0] outstanding_q, outstanding_d;

  // Stage 0 takes the request every cycle; bubbles travel as en=0.
  always_comb begin
    tag_en_d     = tag_en_q;
    tag_mux_d    = tag_mux_q;
    tag_en_d[0]  = rq_en;
    tag_mux_d[0] = rq_muxcode;
    for (int s = 1; s < LATENCY; s++) begin
      tag_en_d[s]  = tag_en_q[s-1];
      tag_mux_d[s] = tag_mux_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_en_q  <= '0;
      tag_mux_q <= '0;
    end else begin
      tag_en_q  <= tag_en_d;
      tag_mux_q <= tag_mux_d;
    end
  end

  assign ret_en   = tag_en_q[LATENCY-1];
  assign ret_mux  = tag_mux_q[LATENCY-1];
  assign ret_i    = ret_en && (ret_mux == 2'd0);
  assign hold_ret = {ret_en && (ret_mux == 2'd2), ret_en && (ret_mux == 2'd1)};
  assign hold_rdy = {c_rdy, d_rdy};

  always_comb begin
    i_vld_d  = ret_i;
    i_data_d = ret_i ? mem_data : i_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_vld_q  <= 1'b0;
      i_data_q <= '0;
    end else begin
      i_vld_q  <= i_vld_d;
      i_data_q <= i_data_d;
    end
  end

  // Holding registers: index 0 is d, index 1 is c.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q[0] <= HOLD_EMPTY;
      hold_q[1] <= HOLD_EMPTY;
    end else begin
      hold_q[0] <= hold_d[0];
      hold_q[1] <= hold_d[1];
    end
  end

  always_comb begin
    for (int h = 0; h < 2; h++) begin
      hold_d[h] = hold_q[h];
      case (hold_q[h])
        HOLD_EMPTY: if (hold_ret[h]) hold_d[h] = HOLD_FULL;
        HOLD_FULL:  if (hold_rdy[h] && !hold_ret[h]) hold_d[h] = HOLD_EMPTY;
      endcase
    end
  end

  // A full register that is not drained this cycle keeps its word and loses the new one.
  always_comb begin
    hold_vld  = '0;
    hold_load = '0;
    hold_drop = '0;
    for (int h = 0; h < 2; h++) begin
      hold_vld[h] = (hold_q[h] == HOLD_FULL);
      case (hold_q[h])
        HOLD_EMPTY: hold_load[h] = hold_ret[h];
        HOLD_FULL: begin
          hold_load[h] = hold_ret[h] && hold_rdy[h];
          hold_drop[h] = hold_ret[h] && !hold_rdy[h];
        end
      endcase
    end
  end

  always_comb begin
    hold_data_d = hold_data_q;
    for (int h = 0; h < 2; h++) begin
      if (hold_load[h]) hold_data_d[h] = mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hold_data_q <= '0;
    else     hold_data_q <= hold_data_d;
  end

  always_comb begin
    ovf_d = ovf_q || (|hold_drop);
    err_d = err_q || (rq_en && (rq_muxcode == 2'd3));
    outstanding_d = outstanding_q;
    if (rq_en && !ret_en)      outstanding_d = outstanding_q + 4'd1;
    else if (!rq_en && ret_en) outstanding_d = outstanding_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q         <= 1'b0;
      err_q         <= 1'b0;
      outstanding_q <= 4'd0;
    end else begin
      ovf_q         <= ovf_d;
      err_q         <= err_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign i_vld       = i_vld_q;
  assign i_data      = i_data_q;
  assign d_vld       = hold_vld[0];
  assign d_data      = hold_data_q[0];
  assign c_vld       = hold_vld[1];
  assign c_data      = hold_data_q[1];
  assign ovf         = ovf_q;
  assign err         = err_q;
  assign outstanding = outstanding_q;

endmodule

// File: tb/tb_rdru.sv
// tb/tb_rdru.sv - randomized and directed bench for rdru against a queue-based return model
module tb_rdru;
  localparam int DATABITS = 64;
  localparam int LATENCY  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                rq_en = 1'b0;
  logic [1:0]          rq_muxcode = 2'd0;
  logic [DATABITS-1:0] mem_data = '0;
  logic                i_vld, d_vld, c_vld, ovf, err;
  logic [DATABITS-1:0] i_data, d_data, c_data;
  logic                d_rdy = 1'b0;
  logic                c_rdy = 1'b0;
  logic [3:0]          outstanding;

  int n_cmp  = 0;
  int n_fail = 0;

  rdru #(.DATABITS(DATABITS), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .rq_en(rq_en), .rq_muxcode(rq_muxcode), .mem_data(mem_data),
    .i_vld(i_vld), .i_data(i_data),
    .d_vld(d_vld), .d_data(d_data), .d_rdy(d_rdy),
    .c_vld(c_vld), .c_data(c_data), .c_rdy(c_rdy),
    .ovf(ovf), .err(err), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  // Reads in flight: cycle their data is due, and who asked.
  int                  pend_due [$];
  logic [1:0]          pend_who [$];
  int                  cyc = 0;
  logic                m_i_vld = 1'b0;
  logic [DATABITS-1:0] m_i_data = '0;
  logic                m_full [2] = '{1'b0, 1'b0};
  logic [DATABITS-1:0] m_data [2] = '{'0, '0};
  logic                m_ovf = 1'b0;
  logic                m_err = 1'b0;

  task automatic check(input string tag, input logic [DATABITS-1:0] obs, input logic [DATABITS-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_update();
    logic [1:0] who;
    logic       rdy [2];
    bit         ret;
    rdy[0] = d_rdy;
    rdy[1] = c_rdy;
    if (rst) begin
      pend_due.delete();
      pend_who.delete();
      m_i_vld = 1'b0;
      m_i_data = '0;
      m_full = '{1'b0, 1'b0};
      m_data = '{'0, '0};
      m_ovf = 1'b0;
      m_err = 1'b0;
    end else begin
      ret = (pend_due.size() > 0) && (pend_due[0] == cyc);
      who = 2'd3;
      if (ret) begin
        who = pend_who[0];
        void'(pend_due.pop_front());
        void'(pend_who.pop_front());
      end
      m_i_vld = ret && (who == 2'd0);
      if (m_i_vld) m_i_data = mem_data;
      for (int h = 0; h < 2; h++) begin
        if (ret && (who == 2'(h + 1))) begin
          if (!m_full[h] || rdy[h]) begin
            m_full[h] = 1'b1;
            m_data[h] = mem_data;
          end else begin
            m_ovf = 1'b1;
          end
        end else if (m_full[h] && rdy[h]) begin
          m_full[h] = 1'b0;
        end
      end
      if (rq_en) begin
        pend_due.push_back(cyc + LATENCY);
        pend_who.push_back(rq_muxcode);
        if (rq_muxcode == 2'd3) m_err = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    check("i_vld", DATABITS'(i_vld), DATABITS'(m_i_vld));
    if (m_i_vld) check("i_data", i_data, m_i_data);
    check("d_vld", DATABITS'(d_vld), DATABITS'(m_full[0]));
    if (m_full[0]) check("d_data", d_data, m_data[0]);
    check("c_vld", DATABITS'(c_vld), DATABITS'(m_full[1]));
    if (m_full[1]) check("c_data", c_data, m_data[1]);
    check("ovf", DATABITS'(ovf), DATABITS'(m_ovf));
    check("err", DATABITS'(err), DATABITS'(m_err));
    check("outstanding", DATABITS'(outstanding), DATABITS'(pend_due.size()));
  endtask

  task automatic step(input logic r, input logic en, input logic [1:0] mx, input logic dr, input logic cr);
    rst = r;
    rq_en = en;
    rq_muxcode = mx;
    d_rdy = dr;
    c_rdy = cr;
    mem_data = {$urandom, $urandom};
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n, input logic dr, input logic cr);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'd0, dr, cr);
  endtask

  initial begin
    // reset state
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    check("reset_outstanding", DATABITS'(outstanding), '0);

    // single i read
    step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    idle(4, 1'b0, 1'b0);

    // three d reads, d_rdy held
    step(1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
    idle(5, 1'b1, 1'b0);

    // two c reads, c_rdy low: second word lost
    step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    idle(4, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b1);
    check("ovf_sticky", DATABITS'(ovf), DATABITS'(1));

    // illegal muxcode
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    idle(4, 1'b0, 1'b0);

    // reset with reads in flight, then a fresh read
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    idle(5, 1'b0, 1'b1);

    // back-to-back d returns into a draining register
    step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
    idle(4, 1'b1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic       r, en, dr, cr;
      logic [1:0] mx;
      r  = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 99) < 65);
      mx = ($urandom_range(0, 39) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      dr = ($urandom_range(0, 99) < 55);
      cr = ($urandom_range(0, 99) < 45);
      step(r, en, mx, dr, cr);
    end
    idle(LATENCY + 2, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/rdru.md
RDRU -- requirements
Module: rdru

Interface
REQ-001 Parameter DATABITS, default 64, width of one read-data word.
REQ-002 Parameter LATENCY, default 2, memory read latency in cycles from request to data; legal range 1..8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 rq_en  input  1  a read was issued to memory this cycle (conflict-detector o_en).
REQ-006 rq_muxcode  input  2  requester of that read: 0=i, 1=d, 2=c, 3=illegal.
REQ-007 mem_data  input  DATABITS  memory read data; valid exactly LATENCY cycles after the matching rq_en.
REQ-008 i_vld  output  1  return valid to requester i (one-cycle pulse, no backpressure).
REQ-009 i_data  output  DATABITS  return data to i.
REQ-010 d_vld  output  1  return valid to requester d, held until d_rdy.
REQ-011 d_data  output  DATABITS  return data to d.
REQ-012 d_rdy  input  1  d accepts d_data this cycle.
REQ-013 c_vld / c_data / c_rdy: same as REQ-010..012 for requester c.
REQ-014 ovf  output  1  sticky: a return was lost because its d or c holding register was occupied.
REQ-015 err  output  1  sticky: rq_en seen with rq_muxcode=3.
REQ-016 outstanding  output  4  number of reads issued but not yet returned (0..LATENCY).

Function
REQ-017 Tag pipeline: LATENCY-stage shift register of {en, muxcode}; stage 0 loads {rq_en, rq_muxcode} every cycle.
REQ-018 Return event: final-stage en=1 in the same cycle mem_data is sampled; destination = final-stage muxcode.
REQ-019 i return: i_vld=1 and i_data=mem_data registered, appearing LATENCY+1 cycles after rq_en; i_vld deasserts the next cycle unless another i return occurs.
REQ-020 d/c holding register: states EMPTY, FULL. EMPTY + return -> FULL, load data. FULL + rdy, no return -> EMPTY. FULL + rdy + return -> FULL, load new data (back-to-back, no bubble). FULL + no rdy + return -> stay FULL, keep old data, drop new, set ovf.
REQ-021 d_vld/c_vld = FULL; d_data/c_data stable while FULL and not accepted.
REQ-022 Returns to d and c in the same cycle are impossible (one read per cycle); i, d, c holding paths are independent.
REQ-023 Muxcode 3 return: no output asserted; err set when the illegal request enters stage 0.
REQ-024 outstanding: +1 on rq_en, -1 on return event; both in same cycle -> unchanged; never wraps (max LATENCY).
REQ-025 ovf and err remain 1 until rst.
REQ-026 rq_en=0 cycles insert bubbles; mem_data ignored when final-stage en=0.

Reset
REQ-027 On rst=1 at a clock edge: all tag-pipeline en bits cleared, d/c registers EMPTY, i_vld=d_vld=c_vld=0, ovf=0, err=0, outstanding=0; data registers reset to 0.
REQ-028 Reads in flight at reset are discarded; mem_data arriving after reset for them produces no return.
REQ-029 rq_en sampled in the cycle rst deasserts (first cycle with rst=0) is tracked normally.

Verification
REQ-030 LATENCY=2: rq_en=1, muxcode=0 at cycle 0, mem_data=0xA5 at cycle 2 -> i_vld=1, i_data=0xA5 at cycle 3 only; outstanding 1 in cycles 1-2, 0 from cycle 3.
REQ-031 Reads to d on cycles 0,1,2, d_rdy=1 held -> d_vld high cycles 3,4,5 with three distinct data words; ovf=0.
REQ-032 Reads to c on cycles 0,1, c_rdy=0 -> c_vld=1 from cycle 3 holding first word; second word dropped, ovf=1 from cycle 4; c_rdy=1 at cycle 6 -> c_vld=0 cycle 7.
REQ-033 rq_en=1, muxcode=3 -> err=1 next cycle; no vld ever asserted for that read; outstanding returns to 0.
REQ-034 Reads at cycles 0,1, rst=1 at cycle 2 -> no vld at cycles 3-4, outstanding=0 after reset; new read at cycle 3 returns normally at cycle 6.
